// File: rtl/rip_config.sv
// rtl/rip_config.sv - CSR address map constants shared across the core
package rip_config;

   // Machine trap setup / handling
   localparam logic [11:0] MTVEC         = 12'h305;
   localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] MSCRATCH      = 12'h340;
   localparam logic [11:0] MEPC          = 12'h341;
   localparam logic [11:0] MCAUSE        = 12'h342;

   // Machine counters (read/write)
   localparam logic [11:0] MCYCLE        = 12'hB00;
   localparam logic [11:0] MINSTRET      = 12'hB02;
   localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] MCYCLEH       = 12'hB80;
   localparam logic [11:0] MINSTRETH     = 12'hB82;
   localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;

   // User-level read-only shadows
   localparam logic [11:0] CYCLE         = 12'hC00;
   localparam logic [11:0] INSTRET       = 12'hC02;
   localparam logic [11:0] HPMCOUNTER3   = 12'hC03;
   localparam logic [11:0] CYCLEH        = 12'hC80;
   localparam logic [11:0] INSTRETH      = 12'hC82;
   localparam logic [11:0] HPMCOUNTER3H  = 12'hC83;

   // hpmcounter3..hpmcounter31 occupy 29 consecutive addresses from each base
   localparam logic [11:0] HPM_LAST_OFS  = 12'd28;

   function automatic logic hpm_in_range(input logic [11:0] num, input logic [11:0] base);
      return (num >= base) && (num <= base + HPM_LAST_OFS);
   endfunction

endpackage

// File: rtl/rip_type.sv
// rtl/rip_type.sv - shared CSR operation and state types
package rip_type;

   typedef enum logic [1:0] {
      CSR_NONE = 2'd0,
      CSR_RW   = 2'd1,
      CSR_RS   = 2'd2,
      CSR_RC   = 2'd3
   } csr_op_t;

   // Plain machine-mode registers; the counters live in rip_csr_counter instances
   typedef struct packed {
      logic [31:0] mtvec;
      logic [31:0] mscratch;
      logic [31:0] mepc;
      logic [31:0] mcause;
      logic [31:0] mcountinhibit;
   } csr_t;

endpackage

// File: rtl/rip_csr_counter.sv
// rtl/rip_csr_counter.sv - one wide event counter with 32-bit half writes
module rip_csr_counter #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             inhibit,
   input  logic             wr_lo,
   input  logic             wr_hi,
   input  logic [31:0]      wdata,
   output logic [CNT_W-1:0] value
);

   logic unused_wdata;
   assign unused_wdata = ^wdata;

   // A CSR write to either half wins over the increment in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) value[31:0] <= wdata;
         if (wr_hi) value[CNT_W-1:32] <= wdata[CNT_W-33:0];
      end else if (inc && !inhibit) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/rip_csr_file.sv
// rtl/rip_csr_file.sv - machine-mode CSR file with counters, trap entry and mret
module rip_csr_file
   import rip_config::*;
   import rip_type::*;
#(
   parameter int          NUM_HPM     = 4,
   parameter int          CNT_W       = 64,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_valid,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_num,
   input  logic [31:0]        csr_wdata,
   output logic [31:0]        csr_rdata,
   output logic               csr_rvalid,
   output logic               csr_illegal,
   input  logic               retire,
   input  logic [NUM_HPM-1:0] hpm_event,
   input  logic               trap_valid,
   input  logic [31:0]        trap_pc,
   input  logic [31:0]        trap_cause,
   input  logic               mret_valid,
   output logic               redirect_valid,
   output logic [31:0]        redirect_pc
);

   // Counter slots: 0 = cycle, 1 = instret, 2+i = hpmcounter3+i
   localparam int          NCNT     = 2 + NUM_HPM;
   localparam logic [63:0] HPM_ONES = (64'd1 << NUM_HPM) - 64'd1;
   localparam logic [31:0] INH_MASK = 32'h0000_0005 | {HPM_ONES[28:0], 3'b000};

   csr_t             csr_q;
   csr_op_t          op;
   logic [CNT_W-1:0] cnt_val [NCNT];
   logic [NCNT-1:0]  cnt_inc, cnt_inh, cnt_wr_lo, cnt_wr_hi;
   logic [63:0]      cnt_rd;
   logic [31:0]      old_val, new_val;
   logic             known, cnt_hit, cnt_hi, wr_req, illegal, do_write;
   int               cnt_idx;
   logic             unused_inh;

   assign unused_inh = ^csr_q.mcountinhibit;
   assign cnt_inc    = {hpm_event, retire, 1'b1};
   assign cnt_inh    = {csr_q.mcountinhibit[3 +: NUM_HPM], csr_q.mcountinhibit[2],
                        csr_q.mcountinhibit[0]};

   // Address decode, old-value mux, legality and Zicsr write-value computation
   always_comb begin
      op      = csr_op_t'(csr_op);
      old_val = '0;
      known   = 1'b1;
      cnt_hit = 1'b0;
      cnt_hi  = 1'b0;
      cnt_idx = 0;
      case (csr_num)
         MTVEC:               old_val = csr_q.mtvec;
         MSCRATCH:            old_val = csr_q.mscratch;
         MEPC:                old_val = csr_q.mepc;
         MCAUSE:              old_val = csr_q.mcause;
         MCOUNTINHIBIT:       old_val = csr_q.mcountinhibit;
         MCYCLE, CYCLE:       cnt_hit = 1'b1;
         MCYCLEH, CYCLEH:     begin cnt_hit = 1'b1; cnt_hi = 1'b1; end
         MINSTRET, INSTRET:   begin cnt_hit = 1'b1; cnt_idx = 1; end
         MINSTRETH, INSTRETH: begin cnt_hit = 1'b1; cnt_hi = 1'b1; cnt_idx = 1; end
         default: begin
            // hpmcounterN sits in slot N-1 (N = csr_num[4:0], 3..31)
            if (hpm_in_range(csr_num, MHPMCOUNTER3) || hpm_in_range(csr_num, HPMCOUNTER3)) begin
               cnt_hit = 1'b1;
               cnt_idx = int'(csr_num[4:0]) - 1;
            end else if (hpm_in_range(csr_num, MHPMCOUNTER3H) ||
                         hpm_in_range(csr_num, HPMCOUNTER3H)) begin
               cnt_hit = 1'b1;
               cnt_hi  = 1'b1;
               cnt_idx = int'(csr_num[4:0]) - 1;
            end else begin
               known = 1'b0;
            end
         end
      endcase
      // Unimplemented hpm slots fall through and read as zero
      cnt_rd = '0;
      for (int k = 0; k < NCNT; k++) begin
         if (cnt_hit && cnt_idx == k) cnt_rd = 64'(cnt_val[k]);
      end
      if (cnt_hit) old_val = cnt_hi ? cnt_rd[63:32] : cnt_rd[31:0];

      wr_req   = csr_valid && ((op == CSR_RW) ||
                 ((op == CSR_RS || op == CSR_RC) && csr_wdata != 32'd0));
      illegal  = csr_valid && (!known || (wr_req && csr_num[11:10] == 2'b11));
      do_write = wr_req && !illegal;
      case (op)
         CSR_RW:  new_val = csr_wdata;
         CSR_RS:  new_val = old_val | csr_wdata;
         CSR_RC:  new_val = old_val & ~csr_wdata;
         default: new_val = old_val;
      endcase
   end

   for (genvar k = 0; k < NCNT; k++) begin : g_cnt
      assign cnt_wr_lo[k] = do_write && cnt_hit && !cnt_hi && (cnt_idx == k);
      assign cnt_wr_hi[k] = do_write && cnt_hit &&  cnt_hi && (cnt_idx == k);
      rip_csr_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .inc     (cnt_inc[k]),
         .inhibit (cnt_inh[k]),
         .wr_lo   (cnt_wr_lo[k]),
         .wr_hi   (cnt_wr_hi[k]),
         .wdata   (new_val),
         .value   (cnt_val[k])
      );
   end

   // Registered read response, register writes, trap entry and mret redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csr_q          <= '{mtvec: MTVEC_RESET & 32'hFFFF_FFFC, default: '0};
         csr_rdata      <= '0;
         csr_rvalid     <= 1'b0;
         csr_illegal    <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         csr_rvalid  <= csr_valid;
         csr_illegal <= illegal;
         csr_rdata   <= (csr_valid && !illegal) ? old_val : 32'd0;
         if (do_write) begin
            case (csr_num)
               MTVEC:         csr_q.mtvec         <= new_val & 32'hFFFF_FFFC;
               MSCRATCH:      csr_q.mscratch      <= new_val;
               MCOUNTINHIBIT: csr_q.mcountinhibit <= new_val & INH_MASK;
               MEPC:          if (!trap_valid) csr_q.mepc   <= new_val & 32'hFFFF_FFFC;
               MCAUSE:        if (!trap_valid) csr_q.mcause <= new_val;
               default:       ;
            endcase
         end
         redirect_valid <= trap_valid || mret_valid;
         if (trap_valid) begin
            csr_q.mepc   <= trap_pc & 32'hFFFF_FFFC;
            csr_q.mcause <= trap_cause;
            redirect_pc  <= csr_q.mtvec;
         end else if (mret_valid) begin
            redirect_pc  <= csr_q.mepc;
         end
      end
   end

endmodule
